// File: rtl/cpsr_flag_ctrl.sv
// Flag-hazard controller between decode and the CPSR register.
// Tracks in-flight flag-setting instructions from execute to writeback, forwards their
// NZCV results to the decode condition check, stalls decode while the flags it needs are
// still in execute, and drives the CPSR per-flag write enables at commit.
module cpsr_flag_ctrl #(
    parameter int unsigned DEPTH  = 3,  // stage 0 = execute, stage DEPTH-1 = commit (2..6)
    parameter int unsigned FLAGSW = 4,  // bit 3=N, 2=Z, 1=C, 0=V
    parameter int unsigned CNTW   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [3:0]        id_cond,
    input  logic              id_setflags,
    input  logic [FLAGSW-1:0] id_mask,
    output logic              id_stall,
    output logic              id_pass,
    input  logic [FLAGSW-1:0] ex_flags,
    input  logic              ex_kill,
    input  logic [FLAGSW-1:0] cpsr_flags,
    output logic [FLAGSW-1:0] shouldsetcpsr,
    output logic [FLAGSW-1:0] cpsrwd,
    output logic [CNTW-1:0]   stall_cnt
);

    localparam logic [3:0] CondAl = 4'b1110;

    logic [DEPTH-1:0]  v_q, v_d;
    logic [FLAGSW-1:0] mask_q  [DEPTH];
    logic [FLAGSW-1:0] mask_d  [DEPTH];
    logic [FLAGSW-1:0] flags_q [DEPTH];
    logic [FLAGSW-1:0] flags_d [DEPTH];
    logic [CNTW-1:0]   stall_cnt_q, stall_cnt_d;

    logic [FLAGSW-1:0] fwd;
    logic              cond_ok;
    logic              issue;
    logic              n_f, z_f, c_f, v_f;

    // Forwarded flags: committed CPSR overlaid oldest-to-newest so the newest entry wins.
    // Stage 0 has no ALU result yet, so it never contributes.
    always_comb begin
        fwd = cpsr_flags;
        for (int i = int'(DEPTH) - 1; i >= 1; i--) begin
            if (v_q[i]) begin
                fwd = (fwd & ~mask_q[i]) | (flags_q[i] & mask_q[i]);
            end
        end
    end

    // ARM condition evaluation on the forwarded flags.
    always_comb begin
        n_f = fwd[3];
        z_f = fwd[2];
        c_f = fwd[1];
        v_f = fwd[0];
        cond_ok = 1'b0;
        case (id_cond)
            4'b0000: cond_ok = z_f;
            4'b0001: cond_ok = !z_f;
            4'b0010: cond_ok = c_f;
            4'b0011: cond_ok = !c_f;
            4'b0100: cond_ok = n_f;
            4'b0101: cond_ok = !n_f;
            4'b0110: cond_ok = v_f;
            4'b0111: cond_ok = !v_f;
            4'b1000: cond_ok = c_f & !z_f;
            4'b1001: cond_ok = !c_f | z_f;
            4'b1010: cond_ok = (n_f == v_f);
            4'b1011: cond_ok = (n_f != v_f);
            4'b1100: cond_ok = !z_f & (n_f == v_f);
            4'b1101: cond_ok = z_f | (n_f != v_f);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;  // reserved "never"
        endcase
    end

    // Hazard stall and issue qualification; a killed execute entry cannot cause a stall.
    always_comb begin
        id_stall = id_valid & (id_cond != CondAl) & v_q[0] & !ex_kill;
        id_pass  = cond_ok & !id_stall;
        issue    = id_valid & !id_stall;
    end

    // Next-state of the tracking pipeline; it shifts every cycle, bubbles enter on no-issue.
    always_comb begin
        v_d[0]     = issue & id_setflags & id_pass;
        mask_d[0]  = issue ? id_mask : '0;
        flags_d[0] = '0;
        v_d[1]     = v_q[0] & !ex_kill;
        mask_d[1]  = mask_q[0];
        flags_d[1] = ex_flags;
        for (int i = 2; i < int'(DEPTH); i++) begin
            v_d[i]     = v_q[i-1];
            mask_d[i]  = mask_q[i-1];
            flags_d[i] = flags_q[i-1];
        end
        stall_cnt_d = stall_cnt_q;
        if (id_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNTW'(1);
        end
    end

    // State registers; reset drops every in-flight flag update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q         <= '0;
            stall_cnt_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mask_q[i]  <= '0;
                flags_q[i] <= '0;
            end
        end else begin
            v_q         <= v_d;
            stall_cnt_q <= stall_cnt_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mask_q[i]  <= mask_d[i];
                flags_q[i] <= flags_d[i];
            end
        end
    end

    // Commit port straight from the last stage register.
    always_comb begin
        shouldsetcpsr = v_q[DEPTH-1] ? mask_q[DEPTH-1] : '0;
        cpsrwd        = flags_q[DEPTH-1];
        stall_cnt     = stall_cnt_q;
    end

endmodule

// File: tb/tb_cpsr_flag_ctrl.sv
// Directed bench for cpsr_flag_ctrl (DEPTH=3): condition table plus hazard sequences.
module tb_cpsr_flag_ctrl;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [3:0]  id_cond;
    logic        id_setflags;
    logic [3:0]  id_mask;
    logic        id_stall;
    logic        id_pass;
    logic [3:0]  ex_flags;
    logic        ex_kill;
    logic [3:0]  cpsr_flags;
    logic [3:0]  shouldsetcpsr;
    logic [3:0]  cpsrwd;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    cpsr_flag_ctrl #(
        .DEPTH (3),
        .FLAGSW(4),
        .CNTW  (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_cond      (id_cond),
        .id_setflags  (id_setflags),
        .id_mask      (id_mask),
        .id_stall     (id_stall),
        .id_pass      (id_pass),
        .ex_flags     (ex_flags),
        .ex_kill      (ex_kill),
        .cpsr_flags   (cpsr_flags),
        .shouldsetcpsr(shouldsetcpsr),
        .cpsrwd       (cpsrwd),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cond;
        logic [3:0] flags;
        logic       pass;
    } vec_t;

    vec_t vecs [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        id_valid    = 1'b0;
        id_setflags = 1'b0;
        id_mask     = 4'b0000;
        ex_kill     = 1'b0;
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        //          cond     flags    pass
        vecs[0]  = '{4'b0000, 4'b0100, 1'b1};  // EQ Z=1
        vecs[1]  = '{4'b0000, 4'b0000, 1'b0};
        vecs[2]  = '{4'b0001, 4'b0000, 1'b1};  // NE
        vecs[3]  = '{4'b0010, 4'b0010, 1'b1};  // CS
        vecs[4]  = '{4'b0011, 4'b0010, 1'b0};  // CC
        vecs[5]  = '{4'b0100, 4'b1000, 1'b1};  // MI
        vecs[6]  = '{4'b0101, 4'b1000, 1'b0};  // PL
        vecs[7]  = '{4'b0110, 4'b0001, 1'b1};  // VS
        vecs[8]  = '{4'b0111, 4'b0000, 1'b1};  // VC
        vecs[9]  = '{4'b1000, 4'b0010, 1'b1};  // HI C=1 Z=0
        vecs[10] = '{4'b1000, 4'b0110, 1'b0};  // HI C=1 Z=1
        vecs[11] = '{4'b1001, 4'b0110, 1'b1};  // LS
        vecs[12] = '{4'b1001, 4'b0010, 1'b0};
        vecs[13] = '{4'b1010, 4'b1001, 1'b1};  // GE N=V=1
        vecs[14] = '{4'b1010, 4'b1000, 1'b0};
        vecs[15] = '{4'b1011, 4'b1000, 1'b1};  // LT
        vecs[16] = '{4'b1100, 4'b0000, 1'b1};  // GT
        vecs[17] = '{4'b1100, 4'b0100, 1'b0};
        vecs[18] = '{4'b1101, 4'b0001, 1'b1};  // LE N!=V
        vecs[19] = '{4'b1101, 4'b0000, 1'b0};
        vecs[20] = '{4'b1110, 4'b0000, 1'b1};  // AL
        vecs[21] = '{4'b1111, 4'b1111, 1'b0};  // never

        // Reset state
        rst_n       = 1'b0;
        id_valid    = 1'b1;
        id_cond     = 4'b0000;
        id_setflags = 1'b0;
        id_mask     = 4'b0000;
        ex_flags    = 4'b0000;
        ex_kill     = 1'b0;
        cpsr_flags  = 4'b0100;
        #2;
        chk("rst_stall", 32'(id_stall), 32'd0);
        chk("rst_pass", 32'(id_pass), 32'd1);
        chk("rst_sset", 32'(shouldsetcpsr), 32'd0);
        chk("rst_wd", 32'(cpsrwd), 32'd0);
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        #1 rst_n = 1'b1;
        step();

        // Condition table with nothing in flight
        foreach (vecs[i]) begin
            id_valid   = 1'b1;
            id_cond    = vecs[i].cond;
            cpsr_flags = vecs[i].flags;
            @(negedge clk);
            chk($sformatf("cond%0d_pass", i), 32'(id_pass), 32'(vecs[i].pass));
            chk($sformatf("cond%0d_stall", i), 32'(id_stall), 32'd0);
            step();
        end
        chk("tbl_sset", 32'(shouldsetcpsr), 32'd0);
        idle(3);

        // Back-to-back hazard: SUBS then BEQ
        cpsr_flags  = 4'b0000;
        id_valid    = 1'b1;
        id_cond     = 4'b1110;
        id_setflags = 1'b1;
        id_mask     = 4'b1111;
        step();
        id_cond     = 4'b0000;
        id_setflags = 1'b0;
        ex_flags    = 4'b0100;
        @(negedge clk);
        chk("haz_stall1", 32'(id_stall), 32'd1);
        chk("haz_pass1", 32'(id_pass), 32'd0);
        step();
        ex_flags = 4'b0000;
        @(negedge clk);
        chk("haz_stall2", 32'(id_stall), 32'd0);
        chk("haz_pass2", 32'(id_pass), 32'd1);
        chk("haz_sset2", 32'(shouldsetcpsr), 32'd0);
        step();
        @(negedge clk);
        chk("haz_sset3", 32'(shouldsetcpsr), 32'b1111);
        chk("haz_wd3", 32'(cpsrwd), 32'b0100);
        chk("haz_pass3", 32'(id_pass), 32'd1);
        chk("haz_cnt", 32'(stall_cnt), 32'd1);
        step();
        @(negedge clk);
        chk("haz_sset4", 32'(shouldsetcpsr), 32'd0);
        idle(3);

        // Newest-wins: A (mask 1111, flags 1000) then B (mask 0010, flags 0010)
        cpsr_flags  = 4'b0000;
        id_valid    = 1'b1;
        id_cond     = 4'b1110;
        id_setflags = 1'b1;
        id_mask     = 4'b1111;
        step();
        id_mask  = 4'b0010;
        ex_flags = 4'b1000;
        @(negedge clk);
        chk("nw_stall_al", 32'(id_stall), 32'd0);
        step();
        id_valid    = 1'b0;
        id_setflags = 1'b0;
        ex_flags    = 4'b0010;
        step();
        id_valid = 1'b1;
        id_cond  = 4'b0010;  // CS
        ex_flags = 4'b0000;
        @(negedge clk);
        chk("nw_cs", 32'(id_pass), 32'd1);
        chk("nw_sset_a", 32'(shouldsetcpsr), 32'b1111);
        chk("nw_wd_a", 32'(cpsrwd), 32'b1000);
        id_cond = 4'b1001;  // LS
        #1;
        chk("nw_ls", 32'(id_pass), 32'd0);
        id_cond = 4'b0100;  // MI
        #1;
        chk("nw_mi", 32'(id_pass), 32'd1);
        step();
        id_valid = 1'b0;
        @(negedge clk);
        chk("nw_sset_b", 32'(shouldsetcpsr), 32'b0010);
        chk("nw_wd_b", 32'(cpsrwd), 32'b0010);
        idle(3);

        // Flush: killed setter must not stall GT; a new setter issued alongside survives
        cpsr_flags  = 4'b0000;
        id_valid    = 1'b1;
        id_cond     = 4'b1110;
        id_setflags = 1'b1;
        id_mask     = 4'b1111;
        step();
        ex_kill     = 1'b1;
        id_cond     = 4'b1100;  // GT
        id_mask     = 4'b0001;
        ex_flags    = 4'b1111;
        @(negedge clk);
        chk("fl_stall", 32'(id_stall), 32'd0);
        chk("fl_pass", 32'(id_pass), 32'd1);
        step();
        ex_kill     = 1'b0;
        id_valid    = 1'b0;
        id_setflags = 1'b0;
        ex_flags    = 4'b0001;
        step();
        ex_flags = 4'b0000;
        @(negedge clk);
        chk("fl_sset_dead", 32'(shouldsetcpsr), 32'd0);
        step();
        @(negedge clk);
        chk("fl_sset_new", 32'(shouldsetcpsr), 32'b0001);
        chk("fl_wd_new", 32'(cpsrwd), 32'b0001);
        idle(3);

        // Failed condition: MOVSNE with Z=1 creates no entry
        cpsr_flags  = 4'b0100;
        id_valid    = 1'b1;
        id_cond     = 4'b0001;
        id_setflags = 1'b1;
        id_mask     = 4'b1100;
        @(negedge clk);
        chk("nf_pass", 32'(id_pass), 32'd0);
        chk("nf_stall", 32'(id_stall), 32'd0);
        step();
        id_valid    = 1'b1;
        id_setflags = 1'b0;
        id_cond     = 4'b0000;  // EQ would stall if an entry had been created
        @(negedge clk);
        chk("nf_nostall", 32'(id_stall), 32'd0);
        id_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge clk);
            chk($sformatf("nf_sset%0d", k), 32'(shouldsetcpsr), 32'd0);
        end
        id_cond    = 4'b1111;
        cpsr_flags = 4'b0000;
        #1;
        chk("nv_pass0", 32'(id_pass), 32'd0);
        idle(2);

        // Async reset mid-flight
        cpsr_flags  = 4'b0000;
        id_valid    = 1'b1;
        id_cond     = 4'b1110;
        id_setflags = 1'b1;
        id_mask     = 4'b1010;
        step();
        id_valid    = 1'b0;
        id_setflags = 1'b0;
        ex_flags    = 4'b1010;
        step();
        ex_flags = 4'b0000;
        step();
        @(negedge clk);
        chk("ar_sset_pre", 32'(shouldsetcpsr), 32'b1010);
        chk("ar_cnt_pre", 32'(stall_cnt), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_sset", 32'(shouldsetcpsr), 32'd0);
        chk("ar_wd", 32'(cpsrwd), 32'd0);
        chk("ar_cnt", 32'(stall_cnt), 32'd0);
        chk("ar_stall", 32'(id_stall), 32'd0);
        step();
        rst_n = 1'b1;
        idle(2);
        chk("ar_sset_post", 32'(shouldsetcpsr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
